apb_master_fsm: RTL and testbench
=================================

Name: apb_master_fsm

Overview:
- Downstream of the bridge's registered AHB-Lite capture stage. Takes one latched request per valid/ready handshake and runs a complete APB3 transfer: a SETUP phase, then an ACCESS phase.
- Handles PREADY wait states, PSLVERR, and an optional access timeout.
- Returns a one-cycle response pulse with read data and error status to the AHB response logic.

Parameters:
- AW, 32, address width of req_addr/paddr
- DW, 32, data width of wdata/rdata paths
- TO_W, 8, width of the access-timeout counter
- TO_MAX, 255, maximum ACCESS cycles before abort. 0 disables the timeout. Must be below 2^TO_W.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  transfer address
- req_wdata  in  DW  write data
- paddr  out  AW  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DW  APB write data
- prdata  in  DW  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DW  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high, sampled only on the rising clk edge.
- Reset values: state IDLE; psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0; paddr, pwdata and rsp_rdata are all zeros; timeout counter 0. While rst=1, req_ready=0.
- States: IDLE, SETUP, ACCESS.
- req_ready = (state==IDLE) & ~rst. It is combinational from the state register.
- IDLE:
  - A handshake (req_valid & req_ready) at edge N registers paddr=req_addr and pwrite=req_write.
  - pwdata=req_wdata for writes, all zeros for reads.
  - Next state is SETUP.
  - If there is no handshake, all APB outputs hold their last values, with psel=0 and penable=0.
- SETUP (cycle N+1): psel=1, penable=0. Unconditionally go to ACCESS and clear the timeout counter.
- ACCESS (cycle N+2 onward): psel=1, penable=1. paddr, pwrite and pwdata are held stable from SETUP through the end of ACCESS.
  - pready=1: the transfer completes this cycle. Register rsp_rdata = pwrite ? 0 : prdata, rsp_err=pslverr, rsp_timeout=0. Next state IDLE.
  - pready=0 and TO_MAX!=0 and counter==TO_MAX-1: abort. Register rsp_err=1, rsp_timeout=1, rsp_rdata=0. Next state IDLE.
  - Otherwise: counter increments; stay in ACCESS.
  - pready=1 in the same cycle as the timeout condition: pready wins, and the transfer completes normally.
  - The ACCESS phase lasts at most TO_MAX cycles when the timeout is enabled.
- Response:
  - rsp_valid=1 for exactly one cycle: the first IDLE cycle after completion or abort.
  - rsp_rdata, rsp_err and rsp_timeout are valid in that cycle and hold their values until the next response.
  - Completion with zero wait states: handshake at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid in cycle N+3.
  - Back-to-back: a request can be accepted in the same cycle rsp_valid=1. Minimum request-to-request spacing is 3 cycles.
- After any transfer ends, psel and penable are 0 in the following cycle. psel is never 1 in IDLE.
- pslverr is sampled only when psel & penable & pready. It is ignored otherwise.
- Reset mid-transfer (rst=1 during SETUP or ACCESS): the next edge forces IDLE and reset values. psel and penable drop, and no rsp_valid is generated for the aborted transfer.
- req_valid while not ready: ignored. The upstream stage holds its request until req_ready=1.

Test Plan:
- Read with zero wait states: req addr=0x0000_0010 (read), pready=1 in the first ACCESS cycle, prdata=0xDEAD_BEEF -> psel rises at N+1, penable at N+2; rsp_valid at N+3 with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write with 3 wait states: addr=0x20, wdata=0x1234_5678, pready low for 3 ACCESS cycles -> paddr/pwdata/pwrite stable for all 5 psel cycles; rsp_valid one cycle, rsp_rdata=0, rsp_err=0.
- Slave error: read with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout with TO_MAX=4: pready held 0 -> ACCESS lasts exactly 4 cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 in the 4th ACCESS cycle -> normal completion, rsp_timeout=0. Repeat with TO_MAX=0 and pready=0 for 1000 cycles -> no abort.
- Back-to-back: req_valid held high with 3 queued requests -> handshakes every 3 cycles; psel drops for exactly 1 IDLE cycle between transfers; 3 rsp_valid pulses in order.
- Reset mid-ACCESS: assert rst in the 2nd ACCESS cycle -> psel=0, penable=0 and rsp_valid=0 after the edge; req_ready=0 while rst=1, then 1 once rst=0.

Source files
------------

// File: rtl/apb_master_fsm.sv
// APB3 master sequencer: accepts one latched request per handshake, runs SETUP/ACCESS,
// handles wait states, slave errors and an optional access timeout, then pulses a response.
module apb_master_fsm #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_W   = 8,
    parameter int TO_MAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    // Request handshake: a transfer is taken on a rising edge where req_valid & req_ready.
    // The upstream stage holds its request stable until that edge; req_ready only depends
    // on the state register and rst.
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [AW-1:0] paddr,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam bit            TO_EN   = (TO_MAX != 0);
    localparam logic [TO_W-1:0] TO_LAST = (TO_MAX == 0) ? '0 : TO_W'(TO_MAX - 1);

    state_t          state, state_nx;
    logic [AW-1:0]   paddr_nx;
    logic            pwrite_nx;
    logic [DW-1:0]   pwdata_nx;
    logic            rsp_valid_nx;
    logic [DW-1:0]   rsp_rdata_nx;
    logic            rsp_err_nx;
    logic            rsp_timeout_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic            hs;

    assign req_ready = (state == IDLE) & ~rst;
    assign hs        = req_valid & req_ready;
    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);
    assign fsm_state = state;

    always_comb begin
        state_nx       = state;
        paddr_nx       = paddr;
        pwrite_nx      = pwrite;
        pwdata_nx      = pwdata;
        rsp_valid_nx   = 1'b0;
        rsp_rdata_nx   = rsp_rdata;
        rsp_err_nx     = rsp_err;
        rsp_timeout_nx = rsp_timeout;
        to_cnt_nx      = to_cnt;
        case (state)
            IDLE: begin
                if (hs) begin
                    paddr_nx  = req_addr;
                    pwrite_nx = req_write;
                    pwdata_nx = req_write ? req_wdata : '0;
                    state_nx  = SETUP;
                end
            end
            SETUP: begin
                to_cnt_nx = '0;
                state_nx  = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a timeout landing in the same cycle
                if (pready) begin
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = pwrite ? '0 : prdata;
                    rsp_err_nx     = pslverr;
                    rsp_timeout_nx = 1'b0;
                    state_nx       = IDLE;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = '0;
                    rsp_err_nx     = 1'b1;
                    rsp_timeout_nx = 1'b1;
                    state_nx       = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nx;
            paddr       <= paddr_nx;
            pwrite      <= pwrite_nx;
            pwdata      <= pwdata_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_err     <= rsp_err_nx;
            rsp_timeout <= rsp_timeout_nx;
            to_cnt      <= to_cnt_nx;
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: planned APB slave, response scoreboard, directed and random traffic,
// plus a second instance with the timeout disabled.
module tb_apb_master_fsm;
    localparam int AW = 32, DW = 32, TO_W = 8, TO_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_valid0, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, prdata;
    logic          pready, pslverr;

    logic          req_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, rsp_rdata;
    logic [1:0]    fsm_state;

    logic          req_ready_0, psel_0, penable_0, pwrite_0, rsp_valid_0, rsp_err_0, rsp_timeout_0;
    logic [AW-1:0] paddr_0;
    logic [DW-1:0] pwdata_0, rsp_rdata_0;
    logic [1:0]    fsm_state_0;

    apb_master_fsm #(.AW(AW), .DW(DW), .TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .fsm_state(fsm_state)
    );

    apb_master_fsm #(.AW(AW), .DW(DW), .TO_W(TO_W), .TO_MAX(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready_0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .paddr(paddr_0), .psel(psel_0), .penable(penable_0), .pwrite(pwrite_0), .pwdata(pwdata_0),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0),
        .rsp_timeout(rsp_timeout_0), .fsm_state(fsm_state_0)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          err;
    } slv_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            cyc;
    } rsp_t;

    slv_t slv_q[$];
    rsp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    logic          ovr = 1'b0;
    logic          ovr_pready = 1'b0;
    logic [DW-1:0] ovr_prdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: a transfer waits 'waits' ACCESS cycles before pready; the timeout fires
    // once the ACCESS phase would need more than TO_MAX cycles.
    function automatic rsp_t model(input slv_t s, input int hs_cyc);
        rsp_t r;
        if (TO_MAX != 0 && s.waits >= TO_MAX) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1; r.cyc = hs_cyc + 2 + TO_MAX;
        end else begin
            r.rdata = s.write ? '0 : s.prdata; r.err = s.err; r.tmo = 1'b0;
            r.cyc = hs_cyc + 3 + s.waits;
        end
        return r;
    endfunction

    // APB slave: follows the plan queued with each request
    slv_t cur;
    int   k = 0;
    always @(negedge clk) begin
        if (ovr) begin
            pready = ovr_pready; prdata = ovr_prdata; pslverr = 1'b0;
        end else if (psel && !penable) begin
            if (slv_q.size() != 0) cur = slv_q.pop_front();
            k = 0;
            check("setup_paddr", paddr, cur.addr);
            check("setup_pwrite", pwrite, cur.write);
            check("setup_pwdata", pwdata, cur.write ? cur.wdata : '0);
            pready = 1'(($urandom) % 2); prdata = $urandom; pslverr = 1'($urandom % 2);
        end else if (psel && penable) begin
            check("access_paddr", paddr, cur.addr);
            check("access_pwrite", pwrite, cur.write);
            check("access_pwdata", pwdata, cur.write ? cur.wdata : '0);
            if (k == cur.waits) begin
                pready = 1'b1; prdata = cur.prdata; pslverr = cur.err;
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom % 2);
            end
            k++;
        end else begin
            pready = 1'($urandom % 2); prdata = $urandom; pslverr = 1'($urandom % 2);
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
                check("rsp_timeout", rsp_timeout, e.tmo);
                check("rsp_cycle", cyc, e.cyc);
                check("psel_in_rsp", psel, 1'b0);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the SETUP cycle with req_valid still high.
    task automatic issue(input slv_t s, input bit expect_rsp, output int hs_cyc);
        int n = 0;
        req_write = s.write; req_addr = s.addr; req_wdata = s.wdata; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
        hs_cyc = cyc;
        slv_q.push_back(s);
        if (expect_rsp) exp_q.push_back(model(s, hs_cyc));
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    function automatic slv_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                                input int wt, input logic [DW-1:0] rd, input logic e);
        slv_t s;
        s.addr = a; s.write = w; s.wdata = wd; s.waits = wt; s.prdata = rd; s.err = e;
        return s;
    endfunction

    initial begin
        slv_t s;
        int h0, h1, h2, bad;
        rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_paddr", paddr, '0);
        check("rst_pwdata", pwdata, '0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1'b1);

        // zero-wait read
        issue(mk(32'h10, 1'b0, $urandom, 0, 32'hDEAD_BEEF, 1'b0), 1'b1, h0);
        req_valid = 1'b0;
        check("setup_psel", psel, 1'b1);
        check("setup_penable", penable, 1'b0);
        @(negedge clk);
        check("access_psel", psel, 1'b1);
        check("access_penable", penable, 1'b1);
        drain();

        // write with 3 wait states, slave error, timeout, pready in last allowed cycle
        issue(mk(32'h20, 1'b1, 32'h1234_5678, 3, $urandom, 1'b0), 1'b1, h0);
        req_valid = 1'b0; drain();
        issue(mk($urandom, 1'b0, $urandom, 1, $urandom, 1'b1), 1'b1, h0);
        req_valid = 1'b0; drain();
        issue(mk($urandom, 1'b0, $urandom, 100, $urandom, 1'b0), 1'b1, h0);
        req_valid = 1'b0; drain();
        issue(mk($urandom, 1'b1, $urandom, 100, $urandom, 1'b1), 1'b1, h0);
        req_valid = 1'b0; drain();
        issue(mk($urandom, 1'b0, $urandom, TO_MAX - 1, $urandom, 1'b0), 1'b1, h0);
        req_valid = 1'b0; drain();

        // back-to-back with req_valid held high
        issue(mk($urandom, 1'b0, $urandom, 0, $urandom, 1'b0), 1'b1, h0);
        issue(mk($urandom, 1'b1, $urandom, 0, $urandom, 1'b0), 1'b1, h1);
        issue(mk($urandom, 1'b0, $urandom, 0, $urandom, 1'b1), 1'b1, h2);
        req_valid = 1'b0;
        check("b2b_spacing_1", h1 - h0, 3);
        check("b2b_spacing_2", h2 - h1, 3);
        drain();

        // random traffic
        for (int i = 0; i < 60; i++) begin
            s = mk($urandom, 1'($urandom % 2), $urandom, $urandom_range(0, 6), $urandom,
                   1'($urandom % 2));
            issue(s, 1'b1, h0);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        drain();

        // timeout disabled: 1000 wait cycles without abort
        ovr = 1'b1; ovr_pready = 1'b0; ovr_prdata = 32'hCAFE_0001;
        req_write = 1'b0; req_addr = 32'h40; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!(psel_0 && penable_0) || rsp_valid_0) bad++;
            @(negedge clk);
        end
        check("no_timeout_wait", bad, 0);
        check("no_timeout_still_access", penable_0, 1'b1);
        ovr_pready = 1'b1;
        @(negedge clk);
        ovr_pready = 1'b0;
        check("to0_rsp_valid", rsp_valid_0, 1'b1);
        check("to0_rsp_timeout", rsp_timeout_0, 1'b0);
        check("to0_rsp_err", rsp_err_0, 1'b0);
        check("to0_rsp_rdata", rsp_rdata_0, 32'hCAFE_0001);
        @(negedge clk);
        check("to0_psel_after", psel_0, 1'b0);
        ovr = 1'b0;

        // reset in the 2nd ACCESS cycle
        issue(mk(32'h80, 1'b0, $urandom, 50, $urandom, 1'b0), 1'b0, h0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_penable", penable, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_psel", psel, 1'b0);
        check("mid_rst_penable", penable, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready, 1'b1);
        @(negedge clk);
        issue(mk(32'h84, 1'b0, $urandom, 2, 32'h0BAD_F00D, 1'b0), 1'b1, h0);
        req_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
